regmap_arbiter: RTL and testbench

- Sequences single-port register-map memory accesses for three requesters: PS write requests, PS read requests (both from the PS request buffer) and one PL-side config requester.
- Runs a round-robin grant, issues exactly one memory transaction at a time, and handles read latency.
- Returns one-cycle completion pulses (wcomplete/rcomplete to the PS request buffer, pl_done to PL).
- Sits between the AXI-lite request buffering and the register memory.

---
 rtl/regmap_pkg.sv | 21 ++
 rtl/regmap_arbiter_rr.sv | 51 +++++
 rtl/regmap_arbiter.sv | 151 +++++++++++++++
 tb/tb_regmap_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/regmap_pkg.sv
// Shared types and sizing for the register-map access path (arbiter and PS request buffer).
package regmap_pkg;

    localparam int RM_DATA_WIDTH  = 32;
    localparam int RM_INDEX_WIDTH = 16;
    localparam int RM_MEM_SIZE    = 256;

    typedef enum logic [1:0] {REQ_PS_W, REQ_PS_R, REQ_PL} req_e;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_e;

    function automatic logic [2:0] req_onehot(input req_e r);
        case (r)
            REQ_PS_W: return 3'b001;
            REQ_PS_R: return 3'b010;
            REQ_PL:   return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/regmap_arbiter_rr.sv
// Three-way round-robin arbiter with request mask; bit 0 = PS write, bit 1 = PS read, bit 2 = PL.
module rr_arbiter3
    import regmap_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_req,
    input  logic [2:0] i_mask,
    input  logic       i_take,
    output logic [2:0] o_grant,
    output logic       o_valid
);

    req_e       r_ptr;
    logic [2:0] w_req;
    logic [2:0] w_rot;
    logic [2:0] w_rgnt;

    // Rotate so the pointer position sits at bit 0, pick lowest, rotate back.
    always_comb begin
        w_req   = i_req & ~i_mask;
        w_rot   = w_req;
        o_grant = '0;
        case (r_ptr)
            REQ_PS_R: w_rot = {w_req[0], w_req[2:1]};
            REQ_PL:   w_rot = {w_req[1:0], w_req[2]};
            default:  w_rot = w_req;
        endcase
        if (w_rot[0])      w_rgnt = 3'b001;
        else if (w_rot[1]) w_rgnt = 3'b010;
        else if (w_rot[2]) w_rgnt = 3'b100;
        else               w_rgnt = 3'b000;
        case (r_ptr)
            REQ_PS_R: o_grant = {w_rgnt[1:0], w_rgnt[2]};
            REQ_PL:   o_grant = {w_rgnt[0], w_rgnt[2:1]};
            default:  o_grant = w_rgnt;
        endcase
        o_valid = |o_grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= REQ_PS_W;
        end else if (i_take) begin
            if (o_grant[0])      r_ptr <= REQ_PS_R;
            else if (o_grant[1]) r_ptr <= REQ_PL;
            else if (o_grant[2]) r_ptr <= REQ_PS_W;
        end
    end

endmodule

// File: rtl/regmap_arbiter.sv
// Serialises PS write, PS read and PL config accesses onto a single-port register memory.
module regmap_arbiter
    import regmap_pkg::*;
#(
    parameter int DATA_WIDTH  = RM_DATA_WIDTH,
    parameter int INDEX_WIDTH = RM_INDEX_WIDTH,
    parameter int MEM_SIZE    = RM_MEM_SIZE,
    parameter int MEM_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ps_write_req,
    input  logic [INDEX_WIDTH-1:0] ps_windex,
    input  logic [DATA_WIDTH-1:0]  ps_wdata,
    input  logic                   ps_read_req,
    input  logic [INDEX_WIDTH-1:0] ps_rindex,
    input  logic                   pl_req,
    input  logic                   pl_we,
    input  logic [INDEX_WIDTH-1:0] pl_index,
    input  logic [DATA_WIDTH-1:0]  pl_wdata,
    output logic                   wcomplete,
    output logic                   rcomplete,
    output logic [DATA_WIDTH-1:0]  ps_rdata,
    output logic                   pl_done,
    output logic [DATA_WIDTH-1:0]  pl_rdata,
    output logic                   access_err,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [INDEX_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic [DATA_WIDTH-1:0]  mem_rdata
);

    localparam logic [INDEX_WIDTH:0] LP_SIZE = (INDEX_WIDTH+1)'(MEM_SIZE);
    localparam logic [2:0]           LP_LAT  = 3'(MEM_LATENCY);

    state_e                 r_state;
    state_e                 w_next;
    req_e                   r_grant;
    logic                   r_we;
    logic [INDEX_WIDTH-1:0] r_index;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [2:0]             r_cnt;
    logic [2:0]             r_holdoff;
    logic [2:0]             w_grant;
    logic                   w_gvalid;
    logic                   w_oor;

    assign w_oor = {1'b0, r_index} >= LP_SIZE;

    rr_arbiter3 u_rr (
        .clk     (clk),
        .rst     (rst),
        .i_req   ({pl_req, ps_read_req, ps_write_req}),
        .i_mask  (r_holdoff),
        .i_take  (r_state == IDLE),
        .o_grant (w_grant),
        .o_valid (w_gvalid)
    );

    always_comb begin
        w_next     = r_state;
        wcomplete  = 1'b0;
        rcomplete  = 1'b0;
        pl_done    = 1'b0;
        access_err = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (r_state)
            IDLE: if (w_gvalid) w_next = ISSUE;
            ISSUE: begin
                if (!w_oor) begin
                    mem_en    = 1'b1;
                    mem_we    = r_we;
                    mem_addr  = r_index;
                    mem_wdata = r_wdata;
                end
                w_next = (r_we || w_oor) ? DONE : WAIT_RD;
            end
            WAIT_RD: if (r_cnt == 3'd1) w_next = DONE;
            DONE: begin
                wcomplete  = (r_grant == REQ_PS_W);
                rcomplete  = (r_grant == REQ_PS_R);
                pl_done    = (r_grant == REQ_PL);
                access_err = w_oor;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= REQ_PS_W;
            r_we      <= 1'b0;
            r_index   <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_holdoff <= '0;
            ps_rdata  <= '0;
            pl_rdata  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    r_holdoff <= '0;
                    if (w_grant[0]) begin
                        r_grant <= REQ_PS_W;
                        r_we    <= 1'b1;
                        r_index <= ps_windex;
                        r_wdata <= ps_wdata;
                    end else if (w_grant[1]) begin
                        r_grant <= REQ_PS_R;
                        r_we    <= 1'b0;
                        r_index <= ps_rindex;
                        r_wdata <= '0;
                    end else if (w_grant[2]) begin
                        r_grant <= REQ_PL;
                        r_we    <= pl_we;
                        r_index <= pl_index;
                        r_wdata <= pl_wdata;
                    end
                end
                ISSUE: begin
                    // Out-of-range reads still overwrite the destination with zero.
                    if (!r_we) begin
                        if (w_oor) begin
                            if (r_grant == REQ_PL) pl_rdata <= '0;
                            else                   ps_rdata <= '0;
                        end else begin
                            r_cnt <= LP_LAT;
                        end
                    end
                end
                WAIT_RD: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        if (r_grant == REQ_PL) pl_rdata <= mem_rdata;
                        else                   ps_rdata <= mem_rdata;
                    end
                end
                DONE: r_holdoff <= req_onehot(r_grant);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regmap_arbiter.sv
// Scoreboard bench for regmap_arbiter with a latency-3 memory model.
module tb_regmap_arbiter;

    localparam int DW  = 32;
    localparam int IW  = 16;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          ps_write_req, ps_read_req, pl_req, pl_we;
    logic [IW-1:0] ps_windex, ps_rindex, pl_index;
    logic [DW-1:0] ps_wdata, pl_wdata;
    logic          wcomplete, rcomplete, pl_done, access_err;
    logic [DW-1:0] ps_rdata, pl_rdata;
    logic          mem_en, mem_we;
    logic [IW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    regmap_arbiter #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .MEM_SIZE(256), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .ps_write_req(ps_write_req), .ps_windex(ps_windex), .ps_wdata(ps_wdata),
        .ps_read_req(ps_read_req), .ps_rindex(ps_rindex),
        .pl_req(pl_req), .pl_we(pl_we), .pl_index(pl_index), .pl_wdata(pl_wdata),
        .wcomplete(wcomplete), .rcomplete(rcomplete), .ps_rdata(ps_rdata),
        .pl_done(pl_done), .pl_rdata(pl_rdata), .access_err(access_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data appears LAT cycles after the enable cycle.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rpipe [LAT];
    bit mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 | i;
            mem_loaded <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        rpipe[0] <= mem[mem_addr[7:0]];
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[LAT-1];

    typedef struct { int kind; bit err; bit chk_data; logic [DW-1:0] data; int cyc; } cpl_t;
    typedef struct { bit we; logic [IW-1:0] addr; logic [DW-1:0] wdata; int cyc; } mtx_t;
    cpl_t cplq[$];
    mtx_t mtxq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a completion or memory access.
    int   np;
    int   kind;
    cpl_t ce;
    mtx_t me;
    always @(negedge clk) begin
        np = int'(wcomplete) + int'(rcomplete) + int'(pl_done);
        if (np > 1) chk("multi_pulse", 64'(np), 64'd1);
        if (np == 1) begin
            if (cplq.size() == 0) begin
                chk("unexp_cpl", 64'(np), 64'd0);
            end else begin
                ce   = cplq.pop_front();
                kind = wcomplete ? 0 : (rcomplete ? 1 : 2);
                chk("cpl_kind", 64'(kind), 64'(ce.kind));
                chk("cpl_err", 64'(access_err), 64'(ce.err));
                chk("cpl_cycle", 64'(cyc), 64'(ce.cyc));
                if (ce.chk_data) chk("cpl_rdata", 64'(kind == 1 ? ps_rdata : pl_rdata), 64'(ce.data));
            end
        end else if (access_err) begin
            chk("err_no_pulse", 64'(access_err), 64'd0);
        end
        if (mem_en) begin
            if (mtxq.size() == 0) begin
                chk("unexp_mem", 64'(mem_en), 64'd0);
            end else begin
                me = mtxq.pop_front();
                chk("mem_we", 64'(mem_we), 64'(me.we));
                chk("mem_addr", 64'(mem_addr), 64'(me.addr));
                chk("mem_cycle", 64'(cyc), 64'(me.cyc));
                if (me.we) chk("mem_wdata", 64'(mem_wdata), 64'(me.wdata));
            end
        end else if (mem_we || mem_addr != '0 || mem_wdata != '0) begin
            chk("mem_idle_zero", {15'd0, mem_we, mem_addr, mem_wdata}, 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push_cpl(input int k, input bit e, input bit cd, input logic [DW-1:0] d, input int c);
        cpl_t t;
        t.kind = k; t.err = e; t.chk_data = cd; t.data = d; t.cyc = c;
        cplq.push_back(t);
    endtask

    task automatic push_mtx(input bit w, input logic [IW-1:0] a, input logic [DW-1:0] d, input int c);
        mtx_t t;
        t.we = w; t.addr = a; t.wdata = d; t.cyc = c;
        mtxq.push_back(t);
    endtask

    // Single request; kind 0=PS write, 1=PS read, 2=PL. Request held through the IDLE after the pulse.
    task automatic access(input int k, input bit we, input logic [IW-1:0] idx,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
        int  c0;
        bit  oor;
        bit  is_wr;
        int  pulse;
        c0    = cyc;
        oor   = idx >= 16'd256;
        is_wr = (k == 0) || (k == 2 && we);
        pulse = (is_wr || oor) ? c0 + 2 : c0 + 2 + LAT;
        if (!oor) push_mtx(is_wr, idx, d, c0 + 1);
        push_cpl(k, oor, !is_wr, oor ? '0 : exp_rd, pulse);
        case (k)
            0: begin ps_write_req = 1'b1; ps_windex = idx; ps_wdata = d; end
            1: begin ps_read_req = 1'b1; ps_rindex = idx; end
            default: begin pl_req = 1'b1; pl_we = we; pl_index = idx; pl_wdata = d; end
        endcase
        wait_until(pulse + 2);
        ps_write_req = 1'b0;
        ps_read_req  = 1'b0;
        pl_req       = 1'b0;
        wait_until(pulse + 4);
    endtask

    int k0;

    initial begin
        rst = 1'b1;
        ps_write_req = 1'b0; ps_read_req = 1'b0; pl_req = 1'b0; pl_we = 1'b0;
        ps_windex = '0; ps_rindex = '0; pl_index = '0; ps_wdata = '0; pl_wdata = '0;
        repeat (3) tick();

        // Requests held through reset: nothing may happen.
        ps_write_req = 1'b1; ps_windex = 16'd10; ps_wdata = 32'h1111_1111;
        ps_read_req  = 1'b1; ps_rindex = 16'd5;
        pl_req = 1'b1; pl_we = 1'b1; pl_index = 16'd20; pl_wdata = 32'h2222_2222;
        tick();
        chk("rst_ctl", 64'({wcomplete, rcomplete, pl_done, access_err, mem_en, mem_we}), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_ps_rdata", 64'(ps_rdata), 64'd0);
        chk("rst_pl_rdata", 64'(pl_rdata), 64'd0);

        // Round robin with all three held: W, R, PL, W, R, PL.
        k0 = cyc;
        rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            push_mtx(1'b1, 16'd10, 32'h1111_1111, k0 + 1 + 12*r);
            push_cpl(0, 1'b0, 1'b0, '0, k0 + 2 + 12*r);
            push_mtx(1'b0, 16'd5, '0, k0 + 4 + 12*r);
            push_cpl(1, 1'b0, 1'b1, 32'hA5A5_0005, k0 + 8 + 12*r);
            push_mtx(1'b1, 16'd20, 32'h2222_2222, k0 + 10 + 12*r);
            push_cpl(2, 1'b0, 1'b0, '0, k0 + 11 + 12*r);
        end
        wait_until(k0 + 23);
        ps_write_req = 1'b0; ps_read_req = 1'b0; pl_req = 1'b0;
        wait_until(k0 + 27);
        chk("mem20", 64'(mem[20]), 64'h2222_2222);

        access(0, 1'b1, 16'd5, 32'hDEAD_BEEF, '0);
        chk("mem5", 64'(mem[5]), 64'hDEAD_BEEF);
        access(1, 1'b0, 16'd5, '0, 32'hDEAD_BEEF);
        access(2, 1'b0, 16'd5, '0, 32'hDEAD_BEEF);
        access(0, 1'b1, 16'd300, 32'h0BAD_0BAD, '0);
        access(2, 1'b0, 16'd300, '0, '0);
        access(2, 1'b1, 16'd7, 32'h7777_0007, '0);
        access(2, 1'b0, 16'd7, '0, 32'h7777_0007);

        // Operands change right after grant; the latched ones must reach memory.
        k0 = cyc;
        push_mtx(1'b1, 16'd6, 32'h1234_5678, k0 + 1);
        push_cpl(0, 1'b0, 1'b0, '0, k0 + 2);
        ps_write_req = 1'b1; ps_windex = 16'd6; ps_wdata = 32'h1234_5678;
        tick();
        ps_wdata = 32'hFFFF_FFFF; ps_windex = 16'd9;
        wait_until(k0 + 4);
        ps_write_req = 1'b0;
        wait_until(k0 + 6);
        chk("mem6_latched", 64'(mem[6]), 64'h1234_5678);
        chk("mem9_untouched", 64'(mem[9]), 64'hA5A5_0009);

        // Reset during a PL read: no pl_done, outputs cleared.
        k0 = cyc;
        push_mtx(1'b0, 16'd5, '0, k0 + 1);
        pl_req = 1'b1; pl_we = 1'b0; pl_index = 16'd5;
        wait_until(k0 + 2);
        rst = 1'b1; pl_req = 1'b0;
        wait_until(k0 + 3);
        chk("mrst_ctl", 64'({wcomplete, rcomplete, pl_done, access_err, mem_en, mem_we}), 64'd0);
        chk("mrst_ps_rdata", 64'(ps_rdata), 64'd0);
        chk("mrst_pl_rdata", 64'(pl_rdata), 64'd0);
        tick();
        rst = 1'b0;
        wait_until(k0 + 12);
        access(0, 1'b1, 16'd8, 32'hCAFE_F00D, '0);
        chk("mem8", 64'(mem[8]), 64'hCAFE_F00D);

        repeat (4) tick();
        chk("cplq_empty", 64'(cplq.size()), 64'd0);
        chk("mtxq_empty", 64'(mtxq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
